// File: rtl/accel_core_pkg.sv
// Shared definitions for the accelerator core: register window base,
// sequencer state encoding and phase-length helpers.
package accel_core_pkg;

   // Base of the accelerator register window and the START_ACCEL offset
   localparam logic [31:0] MMAP_ADDR        = 32'h4000_0000;
   localparam logic [31:0] START_ACCEL_OFFS = 32'h0000_0000;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PRE,
      S_DRAIN,
      S_POST,
      S_FIN
   } seq_state_t;

   // A phase covers end - start + 1 words, which needs one bit more than an address
   localparam int unsigned PHASE_LEN_W = 33;
   typedef logic [PHASE_LEN_W-1:0] phase_len_t;

   // Number of requests an inclusive [first, last] range produces (first <= last)
   function automatic phase_len_t phase_len(input logic [31:0] first,
                                            input logic [31:0] last);
      return {1'b0, last} - {1'b0, first} + 33'd1;
   endfunction

endpackage

// File: rtl/accel_addr_gen.sv
// Address generator for one transfer phase: walks an inclusive word-address
// range, holds the address stable under backpressure and flags the final
// transfer. Termination is by equality with the end address, so a range that
// ends at all-ones finishes without wrapping.
module accel_addr_gen
   import accel_core_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic              stall,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic run;
   logic xfer;

   assign xfer = valid && ready;
   assign last = xfer && (addr == end_addr);

   // Pointer and registered valid; valid follows !stall one cycle late
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      if (rst) begin
         run   <= 1'b0;
         valid <= 1'b0;
         addr  <= '0;
      end else if (load) begin
         run   <= 1'b1;
         valid <= !stall;
         addr  <= start_addr;
      end else if (last) begin
         run   <= 1'b0;
         valid <= 1'b0;
      end else begin
         if (xfer) begin
            addr <= addr + 1'b1;
         end
         valid <= run && !stall;
      end
   end

endmodule

// File: rtl/accel_seq_ctrl.sv
// Accelerator sequencer: on START_ACCEL it latches the preprocess and
// postprocess ranges, validates them, issues one fetch request per preprocess
// word, waits for the input buffer to drain, then issues one writeback request
// per postprocess word and pulses done.
module accel_seq_ctrl
   import accel_core_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pre_start_addr,
   input  logic [ADDR_W-1:0] pre_end_addr,
   input  logic [ADDR_W-1:0] post_start_addr,
   input  logic [ADDR_W-1:0] post_end_addr,
   input  logic              input_buff_full,
   input  logic              input_buff_empty,
   input  logic              output_buff_full,
   input  logic              output_buff_empty,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   seq_state_t        state;
   logic [ADDR_W-1:0] pre_start_lat;
   logic [ADDR_W-1:0] pre_end_lat;
   logic [ADDR_W-1:0] post_start_lat;
   logic [ADDR_W-1:0] post_end_lat;
   logic              range_ok;
   logic              rd_load;
   logic              wr_load;
   logic              rd_last;
   logic              wr_last;
   logic              unused;

   // The full flag of the output buffer is part of the status bundle but
   // does not gate sequencing; writeback only cares whether data is present.
   assign unused = output_buff_full;

   assign range_ok = (pre_end_lat >= pre_start_lat) && (post_end_lat >= post_start_lat);
   assign rd_load  = (state == S_CHECK) && range_ok;
   assign wr_load  = (state == S_DRAIN) && input_buff_empty;

   // Sequencer FSM with registered busy/done/err and the latched ranges
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         pre_start_lat  <= '0;
         pre_end_lat    <= '0;
         post_start_lat <= '0;
         post_end_lat   <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  pre_start_lat  <= pre_start_addr;
                  pre_end_lat    <= pre_end_addr;
                  post_start_lat <= post_start_addr;
                  post_end_lat   <= post_end_addr;
                  busy           <= 1'b1;
                  state          <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (range_ok) begin
                  state <= S_PRE;
               end else begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_PRE: begin
               if (rd_last) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (input_buff_empty) begin
                  state <= S_POST;
               end
            end
            S_POST: begin
               if (wr_last) begin
                  done  <= 1'b1;
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   accel_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
      .clk        (clk),
      .rst        (rst),
      .load       (rd_load),
      .start_addr (pre_start_lat),
      .end_addr   (pre_end_lat),
      .stall      (input_buff_full),
      .ready      (rd_ready),
      .valid      (rd_valid),
      .addr       (rd_addr),
      .last       (rd_last)
   );

   accel_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
      .clk        (clk),
      .rst        (rst),
      .load       (wr_load),
      .start_addr (post_start_lat),
      .end_addr   (post_end_lat),
      .stall      (output_buff_empty),
      .ready      (wr_ready),
      .valid      (wr_valid),
      .addr       (wr_addr),
      .last       (wr_last)
   );

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Directed bench for the accelerator sequencer. Inputs change 1 ns after the
// rising edge; outputs are read at the same point or on the falling edge.
module tb_accel_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] pre_start_addr = '0;
   logic [31:0] pre_end_addr = '0;
   logic [31:0] post_start_addr = '0;
   logic [31:0] post_end_addr = '0;
   logic        input_buff_full = 1'b0;
   logic        input_buff_empty = 1'b1;
   logic        output_buff_full = 1'b0;
   logic        output_buff_empty = 1'b0;
   logic        rd_valid;
   logic [31:0] rd_addr;
   logic        rd_ready = 1'b1;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic        wr_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];
   int          done_cnt = 0;
   int          err_cnt  = 0;
   int          overlap  = 0;

   accel_seq_ctrl #(.ADDR_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .pre_start_addr    (pre_start_addr),
      .pre_end_addr      (pre_end_addr),
      .post_start_addr   (post_start_addr),
      .post_end_addr     (post_end_addr),
      .input_buff_full   (input_buff_full),
      .input_buff_empty  (input_buff_empty),
      .output_buff_full  (output_buff_full),
      .output_buff_empty (output_buff_empty),
      .rd_valid          (rd_valid),
      .rd_addr           (rd_addr),
      .rd_ready          (rd_ready),
      .wr_valid          (wr_valid),
      .wr_addr           (wr_addr),
      .wr_ready          (wr_ready),
      .busy              (busy),
      .done              (done),
      .err               (err)
   );

   always #5 clk = ~clk;

   // Record every handshake that will complete on the next rising edge
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_valid && rd_ready) rd_log.push_back(rd_addr);
         if (wr_valid && wr_ready) wr_log.push_back(wr_addr);
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (rd_valid && wr_valid) overlap++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_log.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic pulse_start(input logic [31:0] ps, input logic [31:0] pe,
                              input logic [31:0] qs, input logic [31:0] qe);
      pre_start_addr  = ps;
      pre_end_addr    = pe;
      post_start_addr = qs;
      post_end_addr   = qe;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy, done, err, rd_valid, wr_valid} !== 5'b0)
         $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, rd_valid, wr_valid});
      else n_pass++;
      n_checks++;
      if ({rd_addr, wr_addr} !== 64'h0)
         $display("FAIL reset_addrs: got rd=%h wr=%h expected 0/0", rd_addr, wr_addr);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] exp_rd [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
      logic [31:0] exp_wr [2] = '{32'h40, 32'h41};
      bit to;
      clear_logs();
      pulse_start(32'h10, 32'h13, 32'h40, 32'h41);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL basic_busy_after_start: got %b expected 1", busy);
      else n_pass++;
      wait_idle(100, to);
      n_checks++;
      if (to !== 1'b0) $display("FAIL basic_timeout: got %b expected 0", to);
      else n_pass++;
      n_checks++;
      if (rd_log.size() !== 4) $display("FAIL basic_rd_count: got %0d expected 4", rd_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_log[i] !== exp_rd[i]) $display("FAIL basic_rd[%0d]: got %h expected %h", i, rd_log[i], exp_rd[i]);
         else n_pass++;
      end
      n_checks++;
      if (wr_log.size() !== 2) $display("FAIL basic_wr_count: got %0d expected 2", wr_log.size());
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (wr_log[i] !== exp_wr[i]) $display("FAIL basic_wr[%0d]: got %h expected %h", i, wr_log[i], exp_wr[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt !== 1) $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_rd [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
      bit to;
      clear_logs();
      pulse_start(32'h10, 32'h13, 32'h40, 32'h40);
      tick();
      n_checks++;
      if ({rd_valid, rd_addr} !== {1'b1, 32'h10}) $display("FAIL bp_first: got v=%b a=%h expected 1/10", rd_valid, rd_addr);
      else n_pass++;
      tick();
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({rd_valid, rd_addr} !== {1'b1, 32'h11}) $display("FAIL bp_hold[%0d]: got v=%b a=%h expected 1/11", i, rd_valid, rd_addr);
         else n_pass++;
      end
      rd_ready = 1'b1;
      input_buff_full = 1'b1;
      tick();
      n_checks++;
      if ({rd_valid, rd_addr} !== {1'b0, 32'h12}) $display("FAIL bp_full_drop: got v=%b a=%h expected 0/12", rd_valid, rd_addr);
      else n_pass++;
      tick();
      n_checks++;
      if ({rd_valid, rd_addr} !== {1'b0, 32'h12}) $display("FAIL bp_full_hold: got v=%b a=%h expected 0/12", rd_valid, rd_addr);
      else n_pass++;
      input_buff_full = 1'b0;
      tick();
      n_checks++;
      if ({rd_valid, rd_addr} !== {1'b1, 32'h12}) $display("FAIL bp_resume: got v=%b a=%h expected 1/12", rd_valid, rd_addr);
      else n_pass++;
      wait_idle(100, to);
      n_checks++;
      if (to !== 1'b0) $display("FAIL bp_timeout: got %b expected 0", to);
      else n_pass++;
      n_checks++;
      if (rd_log.size() !== 4) $display("FAIL bp_rd_count: got %0d expected 4", rd_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rd_log[i] !== exp_rd[i]) $display("FAIL bp_rd[%0d]: got %h expected %h", i, rd_log[i], exp_rd[i]);
         else n_pass++;
      end
      n_checks++;
      if (wr_log.size() !== 1 || wr_log[0] !== 32'h40) $display("FAIL bp_single_write: got n=%0d a=%h expected 1/40", wr_log.size(), wr_log[0]);
      else n_pass++;
   endtask

   task automatic test_range_error();
      clear_logs();
      pulse_start(32'h20, 32'h1F, 32'h40, 32'h41);
      n_checks++;
      if (err !== 1'b0) $display("FAIL err_early: got %b expected 0", err);
      else n_pass++;
      tick();
      n_checks++;
      if ({err, busy} !== 2'b10) $display("FAIL err_pulse: got err=%b busy=%b expected 1/0", err, busy);
      else n_pass++;
      tick();
      n_checks++;
      if ({err, busy} !== 2'b00) $display("FAIL err_after: got err=%b busy=%b expected 0/0", err, busy);
      else n_pass++;
      // Post range inverted as well
      pulse_start(32'h10, 32'h10, 32'h41, 32'h40);
      tick();
      tick();
      n_checks++;
      if ({err_cnt, done_cnt, rd_log.size()} !== {32'd2, 32'd0, 32'd0})
         $display("FAIL err_summary: got err=%0d done=%0d reads=%0d expected 2/0/0", err_cnt, done_cnt, rd_log.size());
      else n_pass++;
   endtask

   task automatic test_all_ones();
      bit to;
      clear_logs();
      input_buff_empty = 1'b0;
      pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (rd_log.size() !== 1 || rd_log[0] !== 32'hFFFF_FFFF)
         $display("FAIL ones_reads: got n=%0d a=%h expected 1/ffffffff", rd_log.size(), rd_log[0]);
      else n_pass++;
      n_checks++;
      if ({busy, rd_valid, wr_valid, rd_addr} !== {3'b100, 32'hFFFF_FFFF})
         $display("FAIL ones_drain: got busy=%b rv=%b wv=%b a=%h expected 1/0/0/ffffffff", busy, rd_valid, wr_valid, rd_addr);
      else n_pass++;
      input_buff_empty = 1'b1;
      wait_idle(50, to);
      n_checks++;
      if (to !== 1'b0 || wr_log.size() !== 1 || wr_log[0] !== 32'h0 || done_cnt !== 1)
         $display("FAIL ones_post: got to=%b n=%0d a=%h done=%0d expected 0/1/0/1", to, wr_log.size(), wr_log[0], done_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_wr [4] = '{32'h40, 32'h41, 32'h42, 32'h43};
      bit to;
      bit seen;
      clear_logs();
      pulse_start(32'h10, 32'h11, 32'h40, 32'h43);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (wr_log.size() >= 1) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (seen !== 1'b1) $display("FAIL rmid_reach_post: got %b expected 1", seen);
      else n_pass++;
      rst = 1'b1;
      start = 1'b1;
      tick();
      n_checks++;
      if ({busy, done, err, rd_valid, wr_valid, rd_addr, wr_addr} !== 69'h0)
         $display("FAIL rmid_outputs: got b=%b d=%b e=%b rv=%b wv=%b ra=%h wa=%h expected all 0", busy, done, err, rd_valid, wr_valid, rd_addr, wr_addr);
      else n_pass++;
      rst = 1'b0;
      start = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rmid_start_with_rst: got busy=%b expected 0", busy);
      else n_pass++;
      clear_logs();
      pulse_start(32'h10, 32'h11, 32'h40, 32'h43);
      wait_idle(100, to);
      n_checks++;
      if (to !== 1'b0 || rd_log.size() !== 2 || rd_log[0] !== 32'h10 || rd_log[1] !== 32'h11)
         $display("FAIL rmid_rerun_reads: got to=%b n=%0d expected 0/2 with 10,11", to, rd_log.size());
      else n_pass++;
      n_checks++;
      if (wr_log.size() !== 4) $display("FAIL rmid_rerun_wr_count: got %0d expected 4", wr_log.size());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wr_log[i] !== exp_wr[i]) $display("FAIL rmid_wr[%0d]: got %h expected %h", i, wr_log[i], exp_wr[i]);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored();
      bit to;
      clear_logs();
      overlap = 0;
      pulse_start(32'h10, 32'h13, 32'h40, 32'h41);
      tick();
      pulse_start(32'h80, 32'h81, 32'h90, 32'h90);
      wait_idle(100, to);
      n_checks++;
      if (to !== 1'b0 || rd_log.size() !== 4 || rd_log[0] !== 32'h10 || rd_log[3] !== 32'h13)
         $display("FAIL ign_reads: got to=%b n=%0d first=%h last=%h expected 0/4/10/13", to, rd_log.size(), rd_log[0], rd_log[3]);
      else n_pass++;
      n_checks++;
      if (wr_log.size() !== 2 || wr_log[0] !== 32'h40 || wr_log[1] !== 32'h41)
         $display("FAIL ign_writes: got n=%0d a0=%h a1=%h expected 2/40/41", wr_log.size(), wr_log[0], wr_log[1]);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if ({busy, done_cnt} !== {1'b0, 32'd1}) $display("FAIL ign_idle: got busy=%b done=%0d expected 0/1", busy, done_cnt);
      else n_pass++;
      n_checks++;
      if (overlap !== 0) $display("FAIL ign_valid_overlap: got %0d expected 0", overlap);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_range_error();
      test_all_ones();
      test_reset_mid();
      test_start_ignored();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/accel_seq_ctrl.md
ACCEL_SEQ_CTRL -- requirements
Module: accel_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all range registers and address outputs.
REQ-002 Port clk  input  1  single clock; all logic rising-edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  one-cycle pulse from START_ACCEL write.
REQ-005 Port pre_start_addr / pre_end_addr  input  ADDR_W  inclusive preprocess word-address range.
REQ-006 Port post_start_addr / post_end_addr  input  ADDR_W  inclusive postprocess word-address range.
REQ-007 Port input_buff_full / input_buff_empty / output_buff_full / output_buff_empty  input  1  buffer status, driven by the core's status master.
REQ-008 Port rd_valid  output  1 / rd_addr  output  ADDR_W / rd_ready  input  1  fetch-request handshake, feeds input buffer.
REQ-009 Port wr_valid  output  1 / wr_addr  output  ADDR_W / wr_ready  input  1  writeback-request handshake, drains output buffer.
REQ-010 Port busy  output  1  high in any state except IDLE.
REQ-011 Port done  output  1  one-cycle pulse on successful completion.
REQ-012 Port err  output  1  one-cycle pulse on rejected start.

Function
REQ-013 FSM states SHALL be IDLE, CHECK, PRE, DRAIN, POST, FIN.
REQ-014 IDLE: on start, latch all four range inputs into internal registers, go to CHECK; start SHALL be ignored in every other state.
REQ-015 CHECK (1 cycle): if latched pre_end < pre_start or post_end < post_start (unsigned), pulse err, go to IDLE; else go to PRE with rd pointer = pre_start.
REQ-016 PRE: rd_valid = !input_buff_full; rd_addr = rd pointer; transfer occurs when rd_valid && rd_ready; pointer increments by 1 per transfer.
REQ-017 rd_addr SHALL remain stable while rd_valid is high and rd_ready low; rd_valid SHALL drop the cycle after input_buff_full rises (registered valid) with no lost or duplicated address.
REQ-018 Transfer of address == pre_end SHALL move to DRAIN; pointer equality, not overflow, terminates, so pre_end = all-ones SHALL not wrap.
REQ-019 DRAIN: wait until input_buff_empty is high, then go to POST with wr pointer = post_start.
REQ-020 POST: wr_valid = !output_buff_empty; same stability, increment and termination rules as PRE using wr_* and post_end.
REQ-021 FIN (1 cycle): done = 1, then IDLE.
REQ-022 Total requests per phase SHALL equal end - start + 1; start == end yields exactly one request.
REQ-023 rd_valid and wr_valid SHALL never be high simultaneously.
REQ-024 Changes to range inputs after the latching cycle SHALL not affect an operation in progress.

Reset
REQ-025 rst SHALL, in any state including mid-transfer, force state IDLE, busy/done/err/rd_valid/wr_valid = 0, rd_addr/wr_addr and all latched registers = 0, next cycle.
REQ-026 A start coincident with rst SHALL be ignored.

Structure
REQ-027 State enum and phase-length constant types SHALL live in accel_core_pkg beside MMAP_ADDR.
REQ-028 One sub-module, accel_addr_gen (pointer, stable-valid handshake, last detection), SHALL be instantiated twice (PRE and POST).
REQ-029 Buffer-status inputs SHALL be connectable directly to the existing core_wr2mmap_inf Slave modport.

Verification
REQ-030 Range 0x10..0x13 / 0x40..0x41, rd_ready=wr_ready=1, empty flags high: rd_addr 0x10,0x11,0x12,0x13; wr_addr 0x40,0x41; one done pulse; busy low after.
REQ-031 Backpressure: rd_ready low 3 cycles at 0x11 -> rd_addr held 0x11; input_buff_full pulsed at 0x12 -> rd_valid low, resumes at 0x12, 4 total reads.
REQ-032 pre_start 0x20, pre_end 0x1F -> err pulse 2 cycles after start, no rd_valid, busy low afterwards.
REQ-033 pre_start=pre_end=0xFFFFFFFF -> exactly one read at 0xFFFFFFFF, then DRAIN; no wrap.
REQ-034 rst asserted during POST after 1 write -> all outputs 0 next cycle; new start runs full sequence from scratch.
REQ-035 start pulsed again during PRE with new ranges -> ignored; original range completes unchanged.
